frame_ctrl_mc: RTL and testbench
================================

Name: frame_ctrl_mc

Overview:
Parametrised multi-channel frame controller for the EyeTracker capture path.
- Accepts one VSYNC per camera channel and keeps a wrapping frame number per channel.
- Detects when all channels have started a frame within a skew window, then issues a single aligned-start strobe.
- Tracks inter-channel frame-number lock; downstream accumulators (sum_s/sum_sx/sum_sy datapath) use it to select frame buffers.

Parameters:
NUM_CH, 2, number of camera channels (1..8)
MAX_FRAME, 3, frame numbers cycle 0..MAX_FRAME-1 (2..16)
FN_WIDTH, 2, frame-number width; must be >= clog2(MAX_FRAME)
WIN_WIDTH, 16, skew-window counter width
SYNC_WIN, 1000, max cycles from first to last channel start (1..2^WIN_WIDTH-1)
LOCK_CNT, 4, consecutive matched aligned starts required to assert lock (1..15)

Ports:
CCLK  in  1  system clock
RST_N  in  1  reset, asynchronous, active-low
iVSYNC  in  NUM_CH  per-channel VSYNC, asynchronous to CCLK, active high
iRESYNC  in  1  synchronous pulse: force all frame numbers to 0, clear lock
oFRAME_NUM  out  NUM_CH*FN_WIDTH  per-channel frame number; channel i at [i*FN_WIDTH +: FN_WIDTH]
oFRAME_START  out  NUM_CH  1-cycle pulse per channel on VSYNC rise
oALL_START  out  1  1-cycle pulse when all channels have started within the window
oSKEW_ERR  out  1  1-cycle pulse on window timeout or a duplicate start
oLOCKED  out  1  level: channels frame-aligned

Behaviour:
- Reset values: all outputs 0; all frame numbers 0; FSM IDLE; mask, window and lock counters 0.
- Input path, per channel:
  - 2-flop synchroniser, then a registered rise detect.
  - VSYNC first sampled high at edge k gives oFRAME_START high in the cycle after edge k+2.
  - The frame number increments on that same edge; MAX_FRAME-1 wraps to 0.
- Gather FSM, states IDLE and COLLECT:
  - IDLE, any start(s) seen: set mask bits, win_cnt=0. If the mask is all ones, pulse oALL_START, stay IDLE and clear the mask; otherwise go to COLLECT.
  - COLLECT, start on a channel whose mask bit is clear: set the bit, win_cnt++.
  - COLLECT, mask becomes all ones: oALL_START pulses the next cycle, return to IDLE, clear the mask.
  - COLLECT, start on a channel whose mask bit is already set: oSKEW_ERR pulses, return to IDLE, clear the mask. That start is discarded for gathering but still counts for the frame number.
  - COLLECT, win_cnt reaches SYNC_WIN-1 with the mask incomplete: oSKEW_ERR pulses, return to IDLE.
  - Simultaneous final start and timeout in the same cycle: completion wins.
  - NUM_CH=1: every start produces oALL_START; the FSM never leaves IDLE.
- Lock, evaluated on each oALL_START using the current frame numbers:
  - All equal: lock_cnt saturates at LOCK_CNT; oLOCKED=1 once lock_cnt==LOCK_CNT.
  - Mismatch: lock_cnt=0, oLOCKED=0, and every channel's frame number is loaded with channel 0's value on the next edge.
  - Any oSKEW_ERR: lock_cnt=0, oLOCKED=0.
- iRESYNC:
  - Next edge: frame numbers=0, mask cleared, FSM to IDLE, lock cleared.
  - Priority over a coincident start or alignment event; that start still pulses oFRAME_START but does not increment.
- Async reset mid-frame returns every register to its reset value immediately. The synchroniser needs a fresh low-to-high transition before the next start.
- Widths: win_cnt is WIN_WIDTH bits and never wraps. The frame number compare is combinational over NUM_CH fields.

Decomposition:
- Package frame_ctrl_pkg: FSM state localparams (IDLE, COLLECT), clog2 function, FN field-slice helper.
- One sub-module vsync_edge: 2-flop synchroniser plus rise detect, instantiated NUM_CH times via generate.
- Counters, FSM and lock logic stay in frame_ctrl_mc.

Test Plan:
- NUM_CH=2: rise both VSYNCs 10 cycles apart, repeated 3 frames. Expect frame numbers 1,2,0 on both channels, one oALL_START per frame, no oSKEW_ERR.
- Channel 1 rises 1001 cycles after channel 0 (SYNC_WIN=1000). Expect oSKEW_ERR exactly at window expiry, no oALL_START, lock cleared.
- Channel 0 rises twice before channel 1. Expect oSKEW_ERR on the second rise; channel 0 frame number advanced by 2.
- Force channel 1 one frame ahead, then aligned starts. Expect oALL_START with mismatch, channel 1 number set to channel 0's value next cycle. After 4 further matched starts, oLOCKED=1 on the 4th oALL_START edge.
- iRESYNC in the same cycle as a channel 0 start. Expect oFRAME_START[0] pulse, all frame numbers 0, oLOCKED=0.
- Assert RST_N low during COLLECT. Expect all outputs 0 asynchronously; after release, the first full frame pair produces oALL_START normally.

Source files
------------

// File: rtl/frame_ctrl_pkg.sv
// rtl/frame_ctrl_pkg.sv - shared types and helpers for the multi-channel frame controller
package frame_ctrl_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } gather_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Low bit of channel ch's field inside a packed frame-number vector.
  function automatic int fn_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/frame_ctrl_mc_if.sv
// rtl/frame_ctrl_mc_if.sv - camera-side inputs and frame-status outputs of frame_ctrl_mc
interface frame_ctrl_mc_if #(
  parameter int NUM_CH   = 2,
  parameter int FN_WIDTH = 2
);
  logic [NUM_CH-1:0]          iVSYNC;
  logic                       iRESYNC;
  logic [NUM_CH*FN_WIDTH-1:0] oFRAME_NUM;
  logic [NUM_CH-1:0]          oFRAME_START;
  logic                       oALL_START;
  logic                       oSKEW_ERR;
  logic                       oLOCKED;

  modport master (
    output iVSYNC, iRESYNC,
    input  oFRAME_NUM, oFRAME_START, oALL_START, oSKEW_ERR, oLOCKED
  );

  modport slave (
    input  iVSYNC, iRESYNC,
    output oFRAME_NUM, oFRAME_START, oALL_START, oSKEW_ERR, oLOCKED
  );
endinterface

// File: rtl/frame_ctrl_mc_vsync_edge.sv
// rtl/frame_ctrl_mc_vsync_edge.sv - VSYNC synchroniser with registered rise detect
// rise_o is the combinational edge seen by the counters; start_o is its registered pulse.
module vsync_edge (
  input  logic CCLK,
  input  logic RST_N,
  input  logic vsync_i,
  output logic rise_o,
  output logic start_o
);
  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic start_q;

  // Flops reset high so a VSYNC held high across reset is not taken as a new frame.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      start_q <= 1'b0;
    end else begin
      meta_q  <= vsync_i;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      start_q <= rise_o;
    end
  end

  assign rise_o  = sync_q & ~prev_q;
  assign start_o = start_q;
endmodule

// File: rtl/frame_ctrl_mc.sv
// rtl/frame_ctrl_mc.sv - per-channel frame numbering, aligned-start gathering and lock tracking
module frame_ctrl_mc
  import frame_ctrl_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int MAX_FRAME = 3,
  parameter int FN_WIDTH  = 2,
  parameter int WIN_WIDTH = 16,
  parameter int SYNC_WIN  = 1000,
  parameter int LOCK_CNT  = 4
) (
  input logic              CCLK,
  input logic              RST_N,
  frame_ctrl_mc_if.slave   bus
);
  localparam int                   LOCK_W   = clog2(LOCK_CNT + 1);
  localparam logic [NUM_CH-1:0]    ALL_ONES = '1;
  localparam logic [WIN_WIDTH-1:0] WIN_LAST = WIN_WIDTH'(SYNC_WIN - 1);
  localparam logic [LOCK_W-1:0]    LOCK_MAX = LOCK_W'(LOCK_CNT);
  localparam logic [FN_WIDTH-1:0]  FN_LAST  = FN_WIDTH'(MAX_FRAME - 1);

  logic [NUM_CH-1:0]          rise;
  logic [NUM_CH-1:0]          start_pulse;
  logic [NUM_CH*FN_WIDTH-1:0] fn_q, fn_d, fn_inc;
  logic                       fn_equal;
  gather_state_e              state_q, state_d;
  logic [NUM_CH-1:0]          mask_q, mask_d, merged;
  logic                       dup;
  logic [WIN_WIDTH-1:0]       win_q, win_d;
  logic                       all_start_q, all_start_d;
  logic                       skew_err_q, skew_err_d;
  logic [LOCK_W-1:0]          lock_q, lock_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_edge
    vsync_edge u_edge (
      .CCLK    (CCLK),
      .RST_N   (RST_N),
      .vsync_i (bus.iVSYNC[g]),
      .rise_o  (rise[g]),
      .start_o (start_pulse[g])
    );
  end

  function automatic logic [FN_WIDTH-1:0] wrap_inc(input logic [FN_WIDTH-1:0] v);
    return (v == FN_LAST) ? '0 : v + FN_WIDTH'(1);
  endfunction

  always_comb begin
    fn_equal = 1'b1;
    for (int i = 1; i < NUM_CH; i++) begin
      if (fn_q[fn_lsb(i, FN_WIDTH) +: FN_WIDTH] != fn_q[FN_WIDTH-1:0]) fn_equal = 1'b0;
    end
  end

  // Realignment copies channel 0's post-increment value so a coincident ch0 start is kept.
  always_comb begin
    fn_inc = fn_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rise[i]) begin
        fn_inc[fn_lsb(i, FN_WIDTH) +: FN_WIDTH] = wrap_inc(fn_q[fn_lsb(i, FN_WIDTH) +: FN_WIDTH]);
      end
    end
    fn_d = fn_inc;
    if (bus.iRESYNC) begin
      fn_d = '0;
    end else if (all_start_q && !fn_equal) begin
      for (int i = 0; i < NUM_CH; i++) begin
        fn_d[fn_lsb(i, FN_WIDTH) +: FN_WIDTH] = fn_inc[FN_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    win_d       = win_q;
    all_start_d = 1'b0;
    skew_err_d  = 1'b0;
    merged      = mask_q | rise;
    dup         = |(mask_q & rise);
    case (state_q)
      ST_IDLE: begin
        if (|rise) begin
          win_d = '0;
          if (rise == ALL_ONES) begin
            all_start_d = 1'b1;
            mask_d      = '0;
          end else begin
            mask_d  = rise;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_COLLECT: begin
        // Completion is tested before the timeout so a last start on the final cycle still wins.
        if (dup) begin
          skew_err_d = 1'b1;
          mask_d     = '0;
          state_d    = ST_IDLE;
        end else if (merged == ALL_ONES) begin
          all_start_d = 1'b1;
          mask_d      = '0;
          state_d     = ST_IDLE;
        end else if (win_q == WIN_LAST) begin
          skew_err_d = 1'b1;
          mask_d     = '0;
          state_d    = ST_IDLE;
        end else begin
          mask_d = merged;
          win_d  = win_q + WIN_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.iRESYNC) begin
      state_d     = ST_IDLE;
      mask_d      = '0;
      win_d       = '0;
      all_start_d = 1'b0;
      skew_err_d  = 1'b0;
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (bus.iRESYNC || skew_err_q) begin
      lock_d = '0;
    end else if (all_start_q) begin
      if (!fn_equal)              lock_d = '0;
      else if (lock_q != LOCK_MAX) lock_d = lock_q + LOCK_W'(1);
    end
  end

  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      win_q       <= '0;
      fn_q        <= '0;
      lock_q      <= '0;
      all_start_q <= 1'b0;
      skew_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      win_q       <= win_d;
      fn_q        <= fn_d;
      lock_q      <= lock_d;
      all_start_q <= all_start_d;
      skew_err_q  <= skew_err_d;
    end
  end

  assign bus.oFRAME_NUM   = fn_q;
  assign bus.oFRAME_START = start_pulse;
  assign bus.oALL_START   = all_start_q;
  assign bus.oSKEW_ERR    = skew_err_q;
  assign bus.oLOCKED      = (lock_q == LOCK_MAX);
endmodule

// File: tb/tb_frame_ctrl_mc.sv
// tb/tb_frame_ctrl_mc.sv - scenario bench for frame_ctrl_mc with an event-level reference model
module tb_frame_ctrl_mc;
  localparam int NUM_CH    = 2;
  localparam int MAX_FRAME = 3;
  localparam int FN_WIDTH  = 2;
  localparam int WIN_WIDTH = 16;
  localparam int SYNC_WIN  = 1000;
  localparam int LOCK_CNT  = 4;
  localparam int FW        = NUM_CH * FN_WIDTH;

  logic CCLK  = 1'b0;
  logic RST_N = 1'b0;

  frame_ctrl_mc_if #(.NUM_CH(NUM_CH), .FN_WIDTH(FN_WIDTH)) bus ();

  frame_ctrl_mc #(
    .NUM_CH(NUM_CH), .MAX_FRAME(MAX_FRAME), .FN_WIDTH(FN_WIDTH),
    .WIN_WIDTH(WIN_WIDTH), .SYNC_WIN(SYNC_WIN), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .CCLK  (CCLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CCLK = ~CCLK;

  int cyc = 0;
  always @(posedge CCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int            as_q[$];
  int            se_q[$];
  int            fs0_q[$];
  int            fs1_q[$];
  int            lk_q[$];
  logic [FW-1:0] as_fn_q[$];
  logic          lk_prev = 1'b0;

  always @(negedge CCLK) begin
    if (bus.oALL_START) begin
      as_q.push_back(cyc);
      as_fn_q.push_back(bus.oFRAME_NUM);
    end
    if (bus.oSKEW_ERR) se_q.push_back(cyc);
    if (bus.oFRAME_START[0]) fs0_q.push_back(cyc);
    if (bus.oFRAME_START[1]) fs1_q.push_back(cyc);
    if (bus.oLOCKED && !lk_prev) lk_q.push_back(cyc);
    lk_prev = bus.oLOCKED;
  end

  // Reference model: frame counts per channel and consecutive matched aligned starts.
  int m_fn[NUM_CH];
  int m_lock;

  function automatic logic [FW-1:0] m_pack();
    logic [FW-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) r[c*FN_WIDTH +: FN_WIDTH] = FN_WIDTH'(m_fn[c]);
    return r;
  endfunction

  function automatic void model_advance(input int c, input int n);
    m_fn[c] = (m_fn[c] + n) % MAX_FRAME;
  endfunction

  function automatic void model_align();
    bit eq;
    eq = 1'b1;
    for (int c = 1; c < NUM_CH; c++) if (m_fn[c] != m_fn[0]) eq = 1'b0;
    if (eq) m_lock = (m_lock < LOCK_CNT) ? m_lock + 1 : LOCK_CNT;
    else begin
      m_lock = 0;
      for (int c = 1; c < NUM_CH; c++) m_fn[c] = m_fn[0];
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) m_fn[c] = 0;
    m_lock = 0;
  endfunction

  // VSYNC pulses (4 cycles high) at relative cycles a0/b0 on ch0 and a1 on ch1; -1 disables.
  task automatic drive(input int a0, input int b0, input int a1, input int len, output int base);
    base = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge CCLK);
      if (i == 0) base = cyc;
      bus.iVSYNC[0] = ((a0 >= 0) && (i >= a0) && (i < a0 + 4)) ||
                      ((b0 >= 0) && (i >= b0) && (i < b0 + 4));
      bus.iVSYNC[1] = (a1 >= 0) && (i >= a1) && (i < a1 + 4);
    end
    bus.iVSYNC = '0;
  endtask

  task automatic do_frame(input int d0, input int d1, input string tag);
    int base, last, n_as, n_se, n_fs0;
    last  = (d0 > d1) ? d0 : d1;
    n_as  = as_q.size();
    n_se  = se_q.size();
    n_fs0 = fs0_q.size();
    drive(d0, -1, d1, last + 10, base);
    model_advance(0, 1);
    model_advance(1, 1);
    model_align();
    checks++;
    if (as_q.size() != n_as + 1) begin
      errors++;
      $display("FAIL %s all_start count: got %0d expected %0d", tag, as_q.size() - n_as, 1);
    end else begin
      checks++;
      if (as_q[n_as] != base + last + 3) begin
        errors++;
        $display("FAIL %s all_start cycle: got %0d expected %0d", tag, as_q[n_as], base + last + 3);
      end
    end
    checks++;
    if (se_q.size() != n_se) begin
      errors++;
      $display("FAIL %s skew_err count: got %0d expected 0", tag, se_q.size() - n_se);
    end
    checks++;
    if (fs0_q.size() != n_fs0 + 1 || fs0_q[n_fs0] != base + d0 + 3) begin
      errors++;
      $display("FAIL %s frame_start0 cycle: got %0d expected %0d", tag,
               (fs0_q.size() > n_fs0) ? fs0_q[n_fs0] : -1, base + d0 + 3);
    end
    checks++;
    if (bus.oFRAME_NUM !== m_pack()) begin
      errors++;
      $display("FAIL %s frame_num: got %h expected %h", tag, bus.oFRAME_NUM, m_pack());
    end
    checks++;
    if (bus.oLOCKED !== (m_lock == LOCK_CNT)) begin
      errors++;
      $display("FAIL %s locked: got %b expected %b", tag, bus.oLOCKED, m_lock == LOCK_CNT);
    end
  endtask

  task automatic test_reset();
    bus.iVSYNC  = '0;
    bus.iRESYNC = 1'b0;
    RST_N       = 1'b0;
    model_reset();
    repeat (3) @(negedge CCLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CCLK);
    checks++;
    if (bus.oFRAME_NUM !== '0) begin errors++; $display("FAIL reset frame_num: got %h expected 0", bus.oFRAME_NUM); end
    checks++;
    if (bus.oFRAME_START !== '0) begin errors++; $display("FAIL reset frame_start: got %b expected 0", bus.oFRAME_START); end
    checks++;
    if (bus.oALL_START !== 1'b0) begin errors++; $display("FAIL reset all_start: got %b expected 0", bus.oALL_START); end
    checks++;
    if (bus.oSKEW_ERR !== 1'b0) begin errors++; $display("FAIL reset skew_err: got %b expected 0", bus.oSKEW_ERR); end
    checks++;
    if (bus.oLOCKED !== 1'b0) begin errors++; $display("FAIL reset locked: got %b expected 0", bus.oLOCKED); end
  endtask

  task automatic test_basic_frames();
    for (int f = 0; f < 3; f++) do_frame(0, 10, "basic");
  endtask

  task automatic test_window_edge();
    do_frame(0, SYNC_WIN, "window_edge");
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 5; f++) begin
      int d;
      d = int'($urandom_range(0, 250));
      if ($urandom_range(0, 1) == 1) do_frame(d, 0, "random");
      else                           do_frame(0, d, "random");
    end
  endtask

  task automatic test_timeout();
    int base, n_as, n_se;
    n_as = as_q.size();
    n_se = se_q.size();
    drive(0, -1, SYNC_WIN + 1, 2 * SYNC_WIN + 20, base);
    model_advance(0, 1);
    model_advance(1, 1);
    m_lock = 0;
    checks++;
    if (se_q.size() != n_se + 2) begin
      errors++;
      $display("FAIL timeout skew_err count: got %0d expected 2", se_q.size() - n_se);
    end else begin
      checks++;
      if (se_q[n_se] != base + 3 + SYNC_WIN) begin
        errors++;
        $display("FAIL timeout first skew_err cycle: got %0d expected %0d", se_q[n_se], base + 3 + SYNC_WIN);
      end
      checks++;
      if (se_q[n_se + 1] != base + SYNC_WIN + 4 + SYNC_WIN) begin
        errors++;
        $display("FAIL timeout second skew_err cycle: got %0d expected %0d", se_q[n_se + 1], base + 2 * SYNC_WIN + 4);
      end
    end
    checks++;
    if (as_q.size() != n_as) begin
      errors++;
      $display("FAIL timeout all_start count: got %0d expected 0", as_q.size() - n_as);
    end
    checks++;
    if (bus.oFRAME_NUM !== m_pack()) begin
      errors++;
      $display("FAIL timeout frame_num: got %h expected %h", bus.oFRAME_NUM, m_pack());
    end
    checks++;
    if (bus.oLOCKED !== 1'b0) begin
      errors++;
      $display("FAIL timeout locked: got %b expected 0", bus.oLOCKED);
    end
  endtask

  task automatic test_duplicate();
    int base, n_as, n_se;
    n_as = as_q.size();
    n_se = se_q.size();
    drive(0, 20, 40, 40 + SYNC_WIN + 20, base);
    model_advance(0, 2);
    model_advance(1, 1);
    m_lock = 0;
    checks++;
    if (se_q.size() != n_se + 2) begin
      errors++;
      $display("FAIL duplicate skew_err count: got %0d expected 2", se_q.size() - n_se);
    end else begin
      checks++;
      if (se_q[n_se] != base + 23) begin
        errors++;
        $display("FAIL duplicate skew_err cycle: got %0d expected %0d", se_q[n_se], base + 23);
      end
    end
    checks++;
    if (as_q.size() != n_as) begin
      errors++;
      $display("FAIL duplicate all_start count: got %0d expected 0", as_q.size() - n_as);
    end
    checks++;
    if (bus.oFRAME_NUM !== m_pack()) begin
      errors++;
      $display("FAIL duplicate frame_num: got %h expected %h", bus.oFRAME_NUM, m_pack());
    end
  endtask

  task automatic test_realign();
    logic [FW-1:0] exp_pre;
    int            n_lk;
    exp_pre = '0;
    for (int c = 0; c < NUM_CH; c++)
      exp_pre[c*FN_WIDTH +: FN_WIDTH] = FN_WIDTH'((m_fn[c] + 1) % MAX_FRAME);
    do_frame(0, 0, "realign");
    checks++;
    if (as_fn_q[as_fn_q.size() - 1] !== exp_pre) begin
      errors++;
      $display("FAIL realign frame_num at all_start: got %h expected %h", as_fn_q[as_fn_q.size() - 1], exp_pre);
    end
    n_lk = lk_q.size();
    for (int f = 0; f < 4; f++) do_frame(0, int'($urandom_range(0, 40)), "relock");
    checks++;
    if (lk_q.size() != n_lk + 1 || lk_q[n_lk] != as_q[as_q.size() - 1] + 1) begin
      errors++;
      $display("FAIL relock locked rise cycle: got %0d expected %0d",
               (lk_q.size() > n_lk) ? lk_q[n_lk] : -1, as_q[as_q.size() - 1] + 1);
    end
  endtask

  task automatic test_resync();
    int n_as, n_se;
    n_as = as_q.size();
    n_se = se_q.size();
    @(negedge CCLK);
    bus.iVSYNC[0] = 1'b1;
    @(negedge CCLK);
    @(negedge CCLK);
    bus.iRESYNC = 1'b1;
    @(negedge CCLK);
    bus.iRESYNC = 1'b0;
    model_reset();
    checks++;
    if (bus.oFRAME_START[0] !== 1'b1) begin
      errors++;
      $display("FAIL resync frame_start0: got %b expected 1", bus.oFRAME_START[0]);
    end
    checks++;
    if (bus.oFRAME_NUM !== m_pack()) begin
      errors++;
      $display("FAIL resync frame_num: got %h expected %h", bus.oFRAME_NUM, m_pack());
    end
    checks++;
    if (bus.oLOCKED !== 1'b0) begin
      errors++;
      $display("FAIL resync locked: got %b expected 0", bus.oLOCKED);
    end
    bus.iVSYNC = '0;
    repeat (SYNC_WIN + 10) @(negedge CCLK);
    checks++;
    if (se_q.size() != n_se || as_q.size() != n_as) begin
      errors++;
      $display("FAIL resync stray events: got %0d expected 0", se_q.size() - n_se + as_q.size() - n_as);
    end
    checks++;
    if (bus.oFRAME_NUM !== m_pack()) begin
      errors++;
      $display("FAIL resync frame_num later: got %h expected %h", bus.oFRAME_NUM, m_pack());
    end
  endtask

  task automatic test_async_reset();
    @(negedge CCLK);
    bus.iVSYNC[0] = 1'b1;
    repeat (4) @(negedge CCLK);
    bus.iVSYNC = '0;
    repeat (2) @(negedge CCLK);
    model_advance(0, 1);
    checks++;
    if (bus.oFRAME_NUM !== m_pack()) begin
      errors++;
      $display("FAIL async_reset pre frame_num: got %h expected %h", bus.oFRAME_NUM, m_pack());
    end
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.oFRAME_NUM, bus.oFRAME_START, bus.oALL_START, bus.oSKEW_ERR, bus.oLOCKED} !== '0) begin
      errors++;
      $display("FAIL async_reset outputs: got %h expected 0",
               {bus.oFRAME_NUM, bus.oFRAME_START, bus.oALL_START, bus.oSKEW_ERR, bus.oLOCKED});
    end
    repeat (3) @(negedge CCLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CCLK);
    do_frame(0, int'($urandom_range(1, 100)), "post_reset");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_frames();
    test_window_edge();
    test_random_frames();
    test_timeout();
    test_duplicate();
    test_realign();
    test_resync();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
